// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one 4-bit adder/subtractor among NUM_REQ clients.
// Optional macro ADDSUB_ARB_STATS_EN adds saturating op/overflow counters.

module AdderSub4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       m,
  output logic [3:0] y,
  output logic       ovf
);

  logic [3:0] bx;
  logic [3:0] lo;
  logic [4:0] full;

  assign bx   = b ^ {4{m}};
  assign lo   = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, m};
  assign full = {1'b0, a} + {1'b0, bx} + {4'b0000, m};
  assign y    = full[3:0];
  // carry out of bit 3 xor carry into bit 3
  assign ovf  = full[4] ^ lo[3];

endmodule

module addsub_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_m,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_y,
`ifdef ADDSUB_ARB_STATS_EN
  output logic                 rsp_ovf,
  output logic [15:0]          op_count,
  output logic [15:0]          ovf_count
`else
  output logic                 rsp_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [ID_W:0]   NW   = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

  state_t state, state_nx;

  logic [ID_W-1:0] ptr;
  logic [3:0]      op_a;
  logic [3:0]      op_b;
  logic            op_m;
  logic [ID_W-1:0] op_id;

  logic            grant_ok;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   best_d;
  logic [ID_W:0]   iw;
  logic [ID_W:0]   pw;
  logic [ID_W:0]   d;

  logic [3:0]      sel_a;
  logic [3:0]      sel_b;
  logic            sel_m;

  logic [3:0]      alu_y;
  logic            alu_ovf;
  logic            take;
  logic            rsp_hs;

  // Pick the valid requester closest to ptr in ascending, wrapping order.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    best_d    = NW;
    pw        = {1'b0, ptr};
    iw        = '0;
    d         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      iw = (ID_W+1)'(i);
      d  = (iw >= pw) ? (iw - pw) : (iw + NW - pw);
      if (req_valid[i] && (d < best_d)) begin
        best_d    = d;
        grant_ok  = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_m = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[4*i +: 4];
        sel_b = req_b[4*i +: 4];
        sel_m = req_m[i];
      end
    end
  end

  assign take   = rst_n && (state == IDLE) && grant_ok;
  assign rsp_hs = (state == RESP) && rsp_valid && rsp_ready;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = take && (grant_idx == ID_W'(i));
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (grant_ok) state_nx = EXEC;
      EXEC: state_nx = RESP;
      RESP: if (rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  AdderSub4bit u_alu (
    .a   (op_a),
    .b   (op_b),
    .m   (op_m),
    .y   (alu_y),
    .ovf (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      op_m  <= 1'b0;
      op_id <= '0;
    end else if (take) begin
      op_a  <= sel_a;
      op_b  <= sel_b;
      op_m  <= sel_m;
      op_id <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      rsp_ovf   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_id    <= op_id;
      rsp_y     <= alu_y;
      rsp_ovf   <= alu_ovf;
    end else if (rsp_hs) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (rsp_hs) begin
      ptr <= (rsp_id == LAST) ? '0 : rsp_id + 1'b1;
    end
  end

`ifdef ADDSUB_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (rsp_hs) begin
      if (op_count != 16'hFFFF) op_count <= op_count + 1'b1;
      if (rsp_ovf && (ovf_count != 16'hFFFF)) begin
        ovf_count <= ovf_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter (NUM_REQ=2).
// Define ADDSUB_ARB_STATS_EN to also exercise the counters.

module tb_addsub_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_m;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_id;
  logic [3:0] rsp_y;
  logic       rsp_ovf;
`ifdef ADDSUB_ARB_STATS_EN
  logic [15:0] op_count;
  logic [15:0] ovf_count;
`endif

  int checks;
  int errors;

  addsub_arbiter #(.NUM_REQ(2), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_m     (req_m),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
`ifdef ADDSUB_ARB_STATS_EN
    .rsp_ovf   (rsp_ovf),
    .op_count  (op_count),
    .ovf_count (ovf_count)
`else
    .rsp_ovf   (rsp_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [3:0] a,
                         input logic [3:0] b, input logic m);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_a[4*idx +: 4] = a;
    req_b[4*idx +: 4] = b;
    req_m[idx] = m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_m = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    req_valid = 2'b01;
    #1;
    checks += 6;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b want 00", req_ready);
    end
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
    end
    if (rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_rsp_id got %0d want 0", rsp_id);
    end
    if (rsp_y !== 4'd0) begin
      errors++;
      $display("FAIL reset_rsp_y got %b want 0000", rsp_y);
    end
    if (rsp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_ovf got %b want 0", rsp_ovf);
    end
    req_valid = '0;
    rst_n = 1'b1;
    tick();
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_add();
    rsp_ready = 1'b1;
    set_req(0, 4'd5, 4'd3, 1'b0);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL add_grant got %b want 01", req_ready);
    end
    tick();
    req_valid = '0;
    checks += 2;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL add_exec_ready got %b want 00", req_ready);
    end
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_exec_valid got %b want 0", rsp_valid);
    end
    tick();
    checks += 4;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_rsp_valid got %b want 1", rsp_valid);
    end
    if (rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL add_rsp_id got %0d want 0", rsp_id);
    end
    if (rsp_y !== 4'b1000) begin
      errors++;
      $display("FAIL add_rsp_y got %b want 1000", rsp_y);
    end
    if (rsp_ovf !== 1'b1) begin
      errors++;
      $display("FAIL add_rsp_ovf got %b want 1", rsp_ovf);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_rsp_drop got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_sub();
    int         idx [3];
    logic [3:0] a   [3];
    logic [3:0] b   [3];
    logic [3:0] ey  [3];
    logic       eo  [3];
    idx = '{1, 0, 1};
    a   = '{4'd3, 4'd8, 4'd0};
    b   = '{4'd5, 4'd1, 4'd8};
    ey  = '{4'b1110, 4'b0111, 4'b1000};
    eo  = '{1'b0, 1'b1, 1'b1};
    rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      set_req(idx[t], a[t], b[t], 1'b1);
      tick();
      req_valid = '0;
      tick();
      checks += 4;
      if (rsp_valid !== 1'b1) begin
        errors++;
        $display("FAIL sub%0d_valid got %b want 1", t, rsp_valid);
      end
      if (rsp_id !== 2'(idx[t])) begin
        errors++;
        $display("FAIL sub%0d_id got %0d want %0d", t, rsp_id, idx[t]);
      end
      if (rsp_y !== ey[t]) begin
        errors++;
        $display("FAIL sub%0d_y got %b want %b", t, rsp_y, ey[t]);
      end
      if (rsp_ovf !== eo[t]) begin
        errors++;
        $display("FAIL sub%0d_ovf got %b want %b", t, rsp_ovf, eo[t]);
      end
      tick();
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy;
    logic [1:0] exp_id;
    logic [3:0] exp_y;
    do_reset();
    rsp_ready = 1'b1;
    req_a = {4'd2, 4'd1};
    req_b = {4'd3, 4'd1};
    req_m = 2'b10;
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 12; c++) begin
      exp_id  = 2'((c / 3) % 2);
      exp_rdy = (c % 3 != 0) ? 2'b00 : ((exp_id == 2'd0) ? 2'b01 : 2'b10);
      exp_y   = (exp_id == 2'd0) ? 4'd2 : 4'hF;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL cont_c%0d_ready got %b want %b", c, req_ready, exp_rdy);
      end
      if (c % 3 == 2) begin
        checks += 3;
        if (rsp_valid !== 1'b1) begin
          errors++;
          $display("FAIL cont_c%0d_valid got %b want 1", c, rsp_valid);
        end
        if (rsp_id !== exp_id) begin
          errors++;
          $display("FAIL cont_c%0d_id got %0d want %0d", c, rsp_id, exp_id);
        end
        if (rsp_y !== exp_y) begin
          errors++;
          $display("FAIL cont_c%0d_y got %b want %b", c, rsp_y, exp_y);
        end
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 4'd7, 4'd1, 1'b0);
    tick();
    req_valid = 2'b10;
    req_a[7:4] = 4'd1;
    req_b[7:4] = 4'd1;
    req_m[1] = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks += 5;
      if (rsp_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_c%0d_valid got %b want 1", c, rsp_valid);
      end
      if (rsp_y !== 4'b1000) begin
        errors++;
        $display("FAIL bp_c%0d_y got %b want 1000", c, rsp_y);
      end
      if (rsp_id !== 2'd0) begin
        errors++;
        $display("FAIL bp_c%0d_id got %0d want 0", c, rsp_id);
      end
      if (rsp_ovf !== 1'b1) begin
        errors++;
        $display("FAIL bp_c%0d_ovf got %b want 1", c, rsp_ovf);
      end
      if (req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_c%0d_ready got %b want 00", c, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks += 2;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_after_valid got %b want 0", rsp_valid);
    end
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_after_grant got %b want 10", req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    set_req(1, 4'd4, 4'd4, 1'b0);
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks += 2;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_valid got %b want 0", rsp_valid);
    end
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_ready got %b want 00", req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ghost got %b want 0", rsp_valid);
    end
    req_a = {4'd1, 4'd6};
    req_b = {4'd1, 4'd1};
    req_m = 2'b00;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_ptr got %b want 01", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    checks += 2;
    if (rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_id got %0d want 0", rsp_id);
    end
    if (rsp_y !== 4'd7) begin
      errors++;
      $display("FAIL rstmid_y got %0d want 7", rsp_y);
    end
    tick();
  endtask

`ifdef ADDSUB_ARB_STATS_EN
  task automatic run_one(input int idx, input logic [3:0] a,
                         input logic [3:0] b, input logic m);
    rsp_ready = 1'b1;
    set_req(idx, a, b, m);
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_stats();
    do_reset();
    checks += 2;
    if (op_count !== 16'd0) begin
      errors++;
      $display("FAIL stats_rst_op got %0d want 0", op_count);
    end
    if (ovf_count !== 16'd0) begin
      errors++;
      $display("FAIL stats_rst_ovf got %0d want 0", ovf_count);
    end
    run_one(0, 4'd1, 4'd1, 1'b0);
    run_one(1, 4'd7, 4'd1, 1'b0);
    run_one(0, 4'd2, 4'd1, 1'b1);
    checks += 2;
    if (op_count !== 16'd3) begin
      errors++;
      $display("FAIL stats_op got %0d want 3", op_count);
    end
    if (ovf_count !== 16'd1) begin
      errors++;
      $display("FAIL stats_ovf got %0d want 1", ovf_count);
    end
    force dut.op_count = 16'hFFFF;
    tick();
    release dut.op_count;
    run_one(1, 4'd1, 4'd1, 1'b0);
    checks += 2;
    if (op_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_sat got %h want ffff", op_count);
    end
    if (ovf_count !== 16'd1) begin
      errors++;
      $display("FAIL stats_sat_ovf got %0d want 1", ovf_count);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_contention();
    test_backpressure();
    test_reset_mid();
`ifdef ADDSUB_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one instance of the team's 4-bit adder/subtractor (AdderSub4bit) among NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Operands are captured into registers; the result and its signed overflow flag are returned on a single response channel tagged with the requester ID.
- Sits between the small ALU clients and the shared arithmetic datapath.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset (sampled on rising clk).
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  4*NUM_REQ  operand A; requester i at bits [4i+3:4i].
- req_b  input  4*NUM_REQ  operand B; same packing as req_a.
- req_m  input  NUM_REQ  mode per requester; 0 = A+B, 1 = A-B.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_y  output  4  result, two's complement, wraps modulo 16.
- rsp_ovf  output  1  signed overflow, i.e. carry-out of bit 3 XOR carry-out of bit 2.

Behaviour:
- FSM with three states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_ovf=0. Round-robin pointer ptr=0. Operand registers = 0.
- IDLE, grant selection:
  - Search req_valid starting at index ptr, ascending, wrapping modulo NUM_REQ.
  - The first set bit wins. req_ready[winner]=1 combinationally in the same cycle; all other bits are 0.
- IDLE, winner present:
  - Capture the winner's A, B, M and index into operand registers.
  - Go to EXEC.
  - The handshake completes that cycle because valid and ready are both high.
- IDLE, no valid request: remain in IDLE; req_ready=0.
- EXEC:
  - Registered operands drive the shared adder. req_ready=0.
  - On the clock edge, register rsp_y and rsp_ovf, and set rsp_id to the captured index and rsp_valid to 1.
  - Go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_ready=0.
  - When rsp_valid && rsp_ready: rsp_valid←0, ptr←(rsp_id+1) mod NUM_REQ, go to IDLE.
- Latency: a request accepted in cycle N gets rsp_valid high in cycle N+2. Minimum issue interval is 3 cycles per operation.
- No new grant while in EXEC or RESP. req_ready is forced to 0 in those states even if req_valid is high.
- Requests not granted must be held by their requesters. The arbiter does not drop or queue them.
- Fairness: a requester that holds valid is served within NUM_REQ grants.
- Arithmetic: subtraction is A + ~B + 1 (carry-in = M).
  - rsp_y is truncated to 4 bits.
  - Unsigned carry-out is not exported.
  - Examples: -8-1 → 0111 with ovf=1; 7+1 → 1000 with ovf=1.
- ptr wraps from NUM_REQ-1 to 0.
- Reset asserted in any state: next edge returns to IDLE with all reset values. An in-flight operation is discarded and no response is issued.
- Requester indices ≥ NUM_REQ do not exist. Unused rsp_id codes are never produced.

Optional Feature:
- Macro: ADDSUB_ARB_STATS_EN.
- Defined: adds outputs op_count[15:0] and ovf_count[15:0], both 0 at reset.
  - op_count increments on each response handshake.
  - ovf_count increments on each response handshake with rsp_ovf=1.
  - Both counters saturate at 16'hFFFF and do not wrap.
- Undefined: these ports and counters are absent, and the behaviour is otherwise identical.

Test Plan:
- Single add: req0 A=5, B=3, M=0, rsp_ready=1 → req_ready[0] high in cycle 0; rsp_valid in cycle 2 with rsp_id=0, rsp_y=4'b1000, rsp_ovf=1.
- Subtract: req1 A=3, B=5, M=1 → rsp_y=4'b1110 (-2), rsp_ovf=0, rsp_id=1. Also check A=8 (-8), B=1, M=1 → rsp_y=4'b0111, ovf=1.
- Contention: req0 and req1 held valid continuously, rsp_ready=1 → grant order 0,1,0,1. Each grant is 3 cycles apart and never two ready bits high at once.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_y, rsp_id and rsp_ovf stable, no req_ready asserted. When rsp_ready rises, the handshake occurs and IDLE follows the next cycle.
- Reset mid-operation: rst_n low during EXEC → next cycle rsp_valid=0 and state IDLE. No response for the discarded operation; ptr=0, so req0 wins next.
- With ADDSUB_ARB_STATS_EN defined: 3 operations with one overflow → op_count=3, ovf_count=1. Forced op_count=16'hFFFF plus one more operation → stays at 16'hFFFF.
